neureka_tcdm_arbiter: RTL and testbench
=======================================

Name: neureka_tcdm_arbiter

Overview:
- Shares the wide TCDM master port between two NEUREKA initiators: requester 0 (activation/output streamer) and requester 1 (weight streamer).
- Splits each granted wide transaction into MP 32-bit TCDM ports and tracks per-port grants arriving in different cycles.
- Reassembles per-port read responses into one wide response and routes it to the owning requester.
- Sits between the NEUREKA streamers and the top-level MP-port TCDM binding.

Parameters:
- BW, NEUREKA_MEM_BANDWIDTH_EXT (288), wide data width in bits; must be a multiple of 32.
- MP, BW/32 (9), number of 32-bit TCDM ports.
- N_OUTSTANDING, 4, depth of the response-owner FIFO, i.e. maximum transactions in flight.

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  asynchronous active-low reset.
- req_i  in  2  per-requester request.
- gnt_o  out  2  per-requester wide grant.
- add_i  in  2x32  per-requester byte address.
- wen_i  in  2  1=read, 0=write.
- be_i  in  2xBW/8  byte enables.
- data_i  in  2xBW  write data.
- r_data_o  out  BW  wide response data, shared by both requesters.
- r_valid_o  out  2  per-requester response valid.
- tcdm_req_o  out  MP  per-port request.
- tcdm_gnt_i  in  MP  per-port grant.
- tcdm_add_o  out  MPx32  per-port address.
- tcdm_wen_o  out  MP  per-port wen.
- tcdm_be_o  out  MPx4  per-port byte enables.
- tcdm_data_o  out  MPx32  per-port write data.
- tcdm_r_data_i  in  MPx32  per-port response data.
- tcdm_r_valid_i  in  MP  per-port response valid.
- busy_o  out  1  transaction locked or responses outstanding.
- err_o  out  1  sticky: a response arrived with the owner FIFO empty.

Behaviour:
- Reset values: all outputs 0; state IDLE; rr_last=1, so requester 0 wins the first tie; grant mask, response mask and FIFO cleared.
- Async reset mid-operation aborts everything; partially granted or in-flight transactions are dropped.
- Requesters hold req/add/wen/be/data stable from req=1 until gnt=1 (HCI rule). The arbiter does not check this.
- Port mapping:
  - Port k takes add+4k, be[4k+3:4k], data[32k+31:32k] and wen, all from the selected requester.
  - tcdm_req_o[k] = sel_valid & ~gmask[k] & issue_ok.
- FSM IDLE:
  - Selection: if only one requester asserts req, select it. If both do, select the one that is not rr_last.
  - issue_ok = FIFO not full.
  - Full grant (tcdm_gnt_i all ones): assert gnt_o[sel] in the same cycle, push {sel} into the FIFO, set rr_last=sel, stay in IDLE.
  - Partial grant: gmask <= tcdm_gnt_i & tcdm_req_o, go to LOCK with sel frozen.
- FSM LOCK:
  - Selection is frozen. Only ports not yet granted request.
  - When (gmask | (tcdm_gnt_i & tcdm_req_o)) is all ones: assert gnt_o[sel] that cycle, push the FIFO, clear gmask, set rr_last, return to IDLE.
  - LOCK never re-arbitrates.
- Grant latency: 0 cycles minimum (combinational gnt_o when all ports grant in the same cycle).
- FIFO:
  - One entry is pushed per wide transaction, reads and writes alike; TCDM returns r_valid for both.
  - Full blocks issue. A pop in the same cycle does not unblock issue (registered full flag).
  - A simultaneous push and pop when not full is legal; count is unchanged.
- Response path:
  - Per-port r_valid captures r_data into rbuf[k] and sets rmask[k].
  - When (rmask | tcdm_r_valid_i) is all ones: r_valid_o[fifo_head]=1 for one cycle; pop the FIFO; clear rmask.
  - r_data_o merges rbuf and live data, with live data taking priority.
  - Response latency: 0 cycles after the last port's r_valid.
  - Responses are in order; each port returns at most one response per outstanding transaction.
- Error case: r_valid on any port while the FIFO is empty and rmask is 0 → set err_o (sticky until reset), discard the data.
- busy_o = (state==LOCK) | FIFO non-empty | rmask!=0.

Decomposition:
- Shared package (neureka_package):
  - NEUREKA_TCDM_ARB_OUTSTANDING constant.
  - typedef arb_state_t {IDLE, LOCK}.
  - typedef for the owner FIFO entry (1-bit requester id).
- Sub-module neureka_arb_owner_fifo: synchronous FIFO with parameterised depth, push/pop/full/empty and registered full flag.

Test Plan (MP=9):
- Single read, requester 0 at 0x1000 with all 9 ports granting at once → tcdm_add = 0x1000..0x1020 step 4 and gnt_o=01 in the same cycle. Drive r_valid all ones 2 cycles later → r_valid_o=01 with r_data_o equal to the concatenated port data.
- Split grant: ports 0-3 grant in cycle 0, ports 4-8 in cycle 2 → state LOCK, tcdm_req_o=0x1F0 in cycles 1-2, gnt_o asserted only in cycle 2.
- Both requesters request continuously → grants alternate 0,1,0,1; the first is requester 0.
- N_OUTSTANDING=4 reads issued with no responses → the 5th request sees tcdm_req_o=0 and busy_o=1. Return one response → the 5th is issued the following cycle.
- Staggered responses: port 8 r_valid 3 cycles after ports 0-7 → a single r_valid_o pulse in port 8's cycle with correct merged data. Owner routing is verified for interleaved requester 1 then requester 0.
- r_valid with the FIFO empty → err_o=1 and held. rst_ni low during LOCK → all outputs 0, state IDLE.

Source files
------------

// File: rtl/neureka_tcdm_arbiter_pkg.sv
// neureka_package: shared constants and types for the NEUREKA TCDM arbiter slice.
package neureka_package;
   localparam int NEUREKA_MEM_BANDWIDTH_EXT    = 288;
   localparam int NEUREKA_TCDM_ARB_OUTSTANDING = 4;
   typedef enum logic {IDLE, LOCK} arb_state_t;
   typedef logic [0:0] arb_owner_t;
endpackage

// File: rtl/neureka_arb_owner_fifo.sv
// neureka_arb_owner_fifo: in-order owner FIFO; full is registered, so a pop
// never frees room for a push within the same cycle.
module neureka_arb_owner_fifo
   import neureka_package::*;
#(
   parameter int DEPTH = NEUREKA_TCDM_ARB_OUTSTANDING
) (
   input  logic       clk_i,
   input  logic       rst_ni,
   input  logic       push_i,
   input  logic       pop_i,
   input  arb_owner_t data_i,
   output arb_owner_t data_o,
   output logic       full_o,
   output logic       empty_o
);
   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = $clog2(DEPTH + 1);
   arb_owner_t    mem_q [DEPTH];
   logic [AW-1:0] wptr_q, rptr_q;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          do_push, do_pop;
   function automatic logic [AW-1:0] wrap_inc(input logic [AW-1:0] p);
      return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
   endfunction
   assign do_push = push_i & ~full_o;
   assign do_pop  = pop_i & ~empty_o;
   assign cnt_d   = cnt_q + CW'(do_push) - CW'(do_pop);
   assign data_o  = mem_q[rptr_q];
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         wptr_q  <= '0;
         rptr_q  <= '0;
         cnt_q   <= '0;
         full_o  <= 1'b0;
         empty_o <= 1'b1;
      end else begin
         if (do_push) wptr_q <= wrap_inc(wptr_q);
         if (do_pop) rptr_q <= wrap_inc(rptr_q);
         cnt_q   <= cnt_d;
         full_o  <= (cnt_d == CW'(DEPTH));
         empty_o <= (cnt_d == '0);
      end
   end
   always_ff @(posedge clk_i) begin
      if (do_push) mem_q[wptr_q] <= data_i;
   end
endmodule

// File: rtl/neureka_tcdm_arbiter.sv
// neureka_tcdm_arbiter: shares the wide TCDM port between two streamers, splitting
// each transaction over MP 32-bit ports and reassembling the wide read response.
module neureka_tcdm_arbiter
   import neureka_package::*;
#(
   parameter int BW            = NEUREKA_MEM_BANDWIDTH_EXT,
   parameter int MP            = BW / 32,
   parameter int N_OUTSTANDING = NEUREKA_TCDM_ARB_OUTSTANDING
) (
   input  logic                 clk_i,
   input  logic                 rst_ni,
   input  logic [1:0]           req_i,
   output logic [1:0]           gnt_o,
   input  logic [1:0][31:0]     add_i,
   input  logic [1:0]           wen_i,
   input  logic [1:0][BW/8-1:0] be_i,
   input  logic [1:0][BW-1:0]   data_i,
   output logic [BW-1:0]        r_data_o,
   output logic [1:0]           r_valid_o,
   output logic [MP-1:0]        tcdm_req_o,
   input  logic [MP-1:0]        tcdm_gnt_i,
   output logic [MP-1:0][31:0]  tcdm_add_o,
   output logic [MP-1:0]        tcdm_wen_o,
   output logic [MP-1:0][3:0]   tcdm_be_o,
   output logic [MP-1:0][31:0]  tcdm_data_o,
   input  logic [MP-1:0][31:0]  tcdm_r_data_i,
   input  logic [MP-1:0]        tcdm_r_valid_i,
   output logic                 busy_o,
   output logic                 err_o
);
   arb_state_t          state_q, state_d;
   arb_owner_t          sel, sel_q, rr_last_q, head;
   logic [MP-1:0]       gmask_q, gmask_d, gdone, rmask_q, rdone;
   logic [MP-1:0][31:0] rbuf_q;
   logic                issue, done, full, empty, orphan, resp;
   // LOCK keeps the requester chosen when the first ports granted
   assign sel        = (state_q == LOCK) ? sel_q :
                       (req_i == 2'b11) ? ~rr_last_q : arb_owner_t'(~req_i[0]);
   assign issue      = req_i[sel] & ~full;
   assign tcdm_req_o = {MP{issue}} & ~gmask_q;
   assign gdone      = gmask_q | (tcdm_gnt_i & tcdm_req_o);
   assign done       = issue & (&gdone);
   assign gnt_o      = {2{done}} & {sel, ~sel};
   always_comb begin
      state_d = state_q;
      gmask_d = gmask_q;
      if (done) begin
         state_d = IDLE;
         gmask_d = '0;
      end else if (|gdone) begin
         state_d = LOCK;
         gmask_d = gdone;
      end
   end
   for (genvar k = 0; k < MP; k++) begin : g_port
      assign tcdm_add_o[k]        = tcdm_req_o[k] ? add_i[sel] + 32'(4 * k) : '0;
      assign tcdm_wen_o[k]        = tcdm_req_o[k] & wen_i[sel];
      assign tcdm_be_o[k]         = tcdm_req_o[k] ? be_i[sel][4*k +: 4] : '0;
      assign tcdm_data_o[k]       = tcdm_req_o[k] ? data_i[sel][32*k +: 32] : '0;
      assign r_data_o[32*k +: 32] = tcdm_r_valid_i[k] ? tcdm_r_data_i[k] : rbuf_q[k];
   end
   // a response with nothing outstanding and nothing collected has no owner
   assign orphan    = (|tcdm_r_valid_i) & empty & ~(|rmask_q);
   assign rdone     = rmask_q | tcdm_r_valid_i;
   assign resp      = (&rdone) & ~empty;
   assign r_valid_o = {2{resp}} & {head, ~head};
   assign busy_o    = (state_q == LOCK) | ~empty | (|rmask_q);
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q   <= IDLE;
         sel_q     <= '0;
         rr_last_q <= 1'b1;
         gmask_q   <= '0;
         rmask_q   <= '0;
         rbuf_q    <= '0;
         err_o     <= 1'b0;
      end else begin
         state_q <= state_d;
         gmask_q <= gmask_d;
         if (state_q == IDLE) sel_q <= sel;
         if (done) rr_last_q <= sel;
         if (orphan) err_o <= 1'b1;
         if (!orphan) begin
            rmask_q <= resp ? '0 : rdone;
            for (int k = 0; k < MP; k++)
               if (tcdm_r_valid_i[k]) rbuf_q[k] <= tcdm_r_data_i[k];
         end
      end
   end
   neureka_arb_owner_fifo #(.DEPTH(N_OUTSTANDING)) i_owner_fifo (
      .clk_i   (clk_i),
      .rst_ni  (rst_ni),
      .push_i  (done),
      .pop_i   (resp),
      .data_i  (sel),
      .data_o  (head),
      .full_o  (full),
      .empty_o (empty)
   );
endmodule

// File: tb/tb_neureka_tcdm_arbiter.sv
// tb_neureka_tcdm_arbiter: directed stimulus with a queue-based model of the
// two-requester arbiter checked every cycle, plus literal spot checks.
module tb_neureka_tcdm_arbiter;
   import neureka_package::*;
   localparam int BW = 288;
   localparam int MP = 9;
   localparam int NO = 4;
   logic                 clk_i = 1'b0;
   logic                 rst_ni = 1'b0;
   logic [1:0]           req_i, gnt_o, wen_i, r_valid_o;
   logic [1:0][31:0]     add_i;
   logic [1:0][BW/8-1:0] be_i;
   logic [1:0][BW-1:0]   data_i;
   logic [BW-1:0]        r_data_o;
   logic [MP-1:0]        tcdm_req_o, tcdm_gnt_i, tcdm_wen_o, tcdm_r_valid_i;
   logic [MP-1:0][31:0]  tcdm_add_o, tcdm_data_o, tcdm_r_data_i;
   logic [MP-1:0][3:0]   tcdm_be_o;
   logic                 busy_o, err_o;
   int                   n_cmp = 0;
   int                   n_bad = 0;

   neureka_tcdm_arbiter #(.BW(BW), .MP(MP), .N_OUTSTANDING(NO)) dut (
      .clk_i(clk_i), .rst_ni(rst_ni), .req_i(req_i), .gnt_o(gnt_o), .add_i(add_i),
      .wen_i(wen_i), .be_i(be_i), .data_i(data_i), .r_data_o(r_data_o),
      .r_valid_o(r_valid_o), .tcdm_req_o(tcdm_req_o), .tcdm_gnt_i(tcdm_gnt_i),
      .tcdm_add_o(tcdm_add_o), .tcdm_wen_o(tcdm_wen_o), .tcdm_be_o(tcdm_be_o),
      .tcdm_data_o(tcdm_data_o), .tcdm_r_data_i(tcdm_r_data_i),
      .tcdm_r_valid_i(tcdm_r_valid_i), .busy_o(busy_o), .err_o(err_o)
   );

   always #5 clk_i = ~clk_i;

   task automatic chk(input string name, input logic [BW-1:0] act, input logic [BW-1:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s @%0t: got %0h, want %0h", name, $time, act, exp);
      end
   endtask

   // model state: owner queue, lock status, granted/collected port sets
   int                  owners[$];
   bit                  m_lock, m_err;
   int                  m_who, m_last;
   bit [MP-1:0]         m_gd, m_got;
   logic [MP-1:0][31:0] m_buf;

   always @(negedge clk_i) begin
      int who, w;
      bit can, all_g, all_r, bad;
      logic [MP-1:0] e_req, e_wen, a_wen;
      logic [MP-1:0][31:0] e_add, e_dat, a_add, a_dat;
      logic [MP-1:0][3:0] e_be, a_be;
      logic [BW-1:0] e_rd;
      logic [1:0] e_gnt, e_rv;
      if (!rst_ni) begin
         owners.delete();
         m_lock = 0; m_err = 0; m_who = 0; m_last = 1;
         m_gd = '0; m_got = '0; m_buf = '0;
      end else begin
         if (m_lock) who = m_who;
         else if (req_i == 2'b11) who = 1 - m_last;
         else if (req_i[0]) who = 0;
         else if (req_i[1]) who = 1;
         else who = -1;
         w = (who < 0) ? 0 : who;
         can = owners.size() < NO;
         all_g = (who >= 0) && can;
         for (int k = 0; k < MP; k++) begin
            e_req[k] = (who >= 0) && can && !m_gd[k];
            e_add[k] = e_req[k] ? add_i[w] + 32'(4 * k) : 32'd0;
            e_dat[k] = e_req[k] ? data_i[w][32*k +: 32] : 32'd0;
            e_be[k]  = e_req[k] ? be_i[w][4*k +: 4] : 4'd0;
            e_wen[k] = e_req[k] & wen_i[w];
            a_add[k] = e_req[k] ? tcdm_add_o[k] : 32'd0;
            a_dat[k] = e_req[k] ? tcdm_data_o[k] : 32'd0;
            a_be[k]  = e_req[k] ? tcdm_be_o[k] : 4'd0;
            a_wen[k] = e_req[k] & tcdm_wen_o[k];
            if (!(m_gd[k] || (e_req[k] && tcdm_gnt_i[k]))) all_g = 0;
         end
         e_gnt = '0;
         if (all_g) e_gnt[w] = 1'b1;
         bad = (|tcdm_r_valid_i) && owners.size() == 0 && m_got == '0;
         all_r = (&(m_got | tcdm_r_valid_i)) && owners.size() > 0;
         e_rv = '0;
         if (all_r) e_rv[owners[0]] = 1'b1;
         for (int k = 0; k < MP; k++)
            e_rd[32*k +: 32] = tcdm_r_valid_i[k] ? tcdm_r_data_i[k] : m_buf[k];
         chk("m_gnt", BW'(gnt_o), BW'(e_gnt));
         chk("m_tcdm_req", BW'(tcdm_req_o), BW'(e_req));
         chk("m_tcdm_add", BW'(a_add), BW'(e_add));
         chk("m_tcdm_data", BW'(a_dat), BW'(e_dat));
         chk("m_tcdm_be", BW'(a_be), BW'(e_be));
         chk("m_tcdm_wen", BW'(a_wen), BW'(e_wen));
         chk("m_r_valid", BW'(r_valid_o), BW'(e_rv));
         if (all_r) chk("m_r_data", r_data_o, e_rd);
         chk("m_busy", BW'(busy_o), BW'(m_lock || owners.size() > 0 || m_got != '0));
         chk("m_err", BW'(err_o), BW'(m_err));
         if (bad) m_err = 1;
         else begin
            for (int k = 0; k < MP; k++)
               if (tcdm_r_valid_i[k]) m_buf[k] = tcdm_r_data_i[k];
            if (all_r) begin
               void'(owners.pop_front());
               m_got = '0;
            end else m_got |= tcdm_r_valid_i;
         end
         if (all_g) begin
            owners.push_back(who);
            m_last = who; m_lock = 0; m_gd = '0;
         end else if (|(e_req & tcdm_gnt_i)) begin
            m_lock = 1; m_who = who; m_gd |= e_req & tcdm_gnt_i;
         end
      end
   end

   task automatic step();
      @(posedge clk_i);
      #1;
   endtask

   task automatic idle_in();
      req_i = '0; tcdm_gnt_i = '0; tcdm_r_valid_i = '0;
   endtask

   task automatic rsp(input logic [MP-1:0] v, input logic [31:0] base);
      tcdm_r_valid_i = v;
      for (int k = 0; k < MP; k++) tcdm_r_data_i[k] = base + 32'(k);
   endtask

   initial begin
      idle_in();
      wen_i = '0; add_i = '0; tcdm_r_data_i = '0;
      be_i[0] = '1; be_i[1] = 36'h9_8765_4321;
      for (int r = 0; r < 2; r++)
         for (int k = 0; k < MP; k++) data_i[r][32*k +: 32] = $urandom;
      repeat (2) step();
      #2;
      chk("reset_gnt", BW'(gnt_o), 0);
      chk("reset_tcdm_req", BW'(tcdm_req_o), 0);
      chk("reset_busy", BW'(busy_o), 0);
      chk("reset_err", BW'(err_o), 0);
      chk("reset_r_data", r_data_o, 0);
      step(); rst_ni = 1'b1;
      // single read, all ports grant at once
      step(); req_i = 2'b01; add_i[0] = 32'h1000; wen_i = 2'b11; tcdm_gnt_i = '1;
      #2;
      chk("rd_add0", BW'(tcdm_add_o[0]), BW'(32'h1000));
      chk("rd_add8", BW'(tcdm_add_o[8]), BW'(32'h1020));
      chk("rd_gnt", BW'(gnt_o), BW'(2'b01));
      chk("rd_req", BW'(tcdm_req_o), BW'(9'h1FF));
      step(); idle_in(); #2;
      chk("rd_busy", BW'(busy_o), 1);
      step(); rsp('1, 32'hD000_0000); #2;
      chk("rd_rvalid", BW'(r_valid_o), BW'(2'b01));
      chk("rd_rdata", r_data_o,
          288'hD0000008_D0000007_D0000006_D0000005_D0000004_D0000003_D0000002_D0000001_D0000000);
      step(); idle_in(); #2;
      chk("rd_idle", BW'(busy_o), 0);
      // split grant from requester 1: ports 0-3 then ports 4-8 two cycles later
      step(); req_i = 2'b10; add_i[1] = 32'h2000; wen_i = 2'b01; tcdm_gnt_i = 9'h00F; #2;
      chk("split_gnt0", BW'(gnt_o), 0);
      chk("split_be0", BW'(tcdm_be_o[0]), BW'(4'h1));
      chk("split_be8", BW'(tcdm_be_o[8]), BW'(4'h9));
      step(); tcdm_gnt_i = '0; #2;
      chk("split_req1", BW'(tcdm_req_o), BW'(9'h1F0));
      chk("split_busy", BW'(busy_o), 1);
      step(); tcdm_gnt_i = 9'h1F0; #2;
      chk("split_req2", BW'(tcdm_req_o), BW'(9'h1F0));
      chk("split_gnt2", BW'(gnt_o), BW'(2'b10));
      step(); idle_in();
      step(); rsp('1, 32'hC000_0000); #2;
      chk("split_rvalid", BW'(r_valid_o), BW'(2'b10));
      // both request: alternate 0,1,0,1 then FIFO full blocks the fifth
      step(); idle_in(); req_i = 2'b11; add_i[0] = 32'h3000; add_i[1] = 32'h4000;
      wen_i = 2'b11; tcdm_gnt_i = '1; #2;
      chk("rr_gnt0", BW'(gnt_o), BW'(2'b01));
      step(); #2; chk("rr_gnt1", BW'(gnt_o), BW'(2'b10));
      step(); #2; chk("rr_gnt2", BW'(gnt_o), BW'(2'b01));
      step(); #2; chk("rr_gnt3", BW'(gnt_o), BW'(2'b10));
      step(); #2;
      chk("full_req", BW'(tcdm_req_o), 0);
      chk("full_busy", BW'(busy_o), 1);
      step(); rsp('1, 32'hB000_0000); #2;
      chk("full_pop_rvalid", BW'(r_valid_o), BW'(2'b01));
      chk("full_pop_req", BW'(tcdm_req_o), 0);
      step(); tcdm_r_valid_i = '0; #2;
      chk("full_reissue", BW'(gnt_o), BW'(2'b01));
      step(); idle_in();
      // owners now 1,0,1,0: staggered response for requester 1
      step(); rsp(9'h0FF, 32'hE000_0000); #2;
      chk("stag_none0", BW'(r_valid_o), 0);
      step(); tcdm_r_valid_i = '0;
      step();
      step(); rsp(9'h100, 32'hE000_0000);
      for (int k = 0; k < 8; k++) tcdm_r_data_i[k] = 32'hBAD;
      #2;
      chk("stag_rvalid", BW'(r_valid_o), BW'(2'b10));
      chk("stag_rdata", r_data_o,
          288'hE0000008_E0000007_E0000006_E0000005_E0000004_E0000003_E0000002_E0000001_E0000000);
      step(); rsp('1, 32'hF000_0000); #2;
      chk("route_r0", BW'(r_valid_o), BW'(2'b01));
      step(); rsp('1, 32'hA100_0000); #2;
      chk("route_r1", BW'(r_valid_o), BW'(2'b10));
      step(); rsp('1, 32'hA200_0000); #2;
      chk("route_r0b", BW'(r_valid_o), BW'(2'b01));
      step(); idle_in(); #2;
      chk("drain_busy", BW'(busy_o), 0);
      // orphan response sets sticky error
      step(); rsp(9'h001, 32'h55); #2;
      chk("orphan_rvalid", BW'(r_valid_o), 0);
      step(); idle_in(); #2;
      chk("err_set", BW'(err_o), 1);
      step(); step(); #2;
      chk("err_held", BW'(err_o), 1);
      chk("err_busy", BW'(busy_o), 0);
      // reset while locked
      step(); req_i = 2'b01; add_i[0] = 32'h5000; tcdm_gnt_i = 9'h001; #2;
      chk("lk_gnt", BW'(gnt_o), 0);
      step(); tcdm_gnt_i = '0; #2;
      chk("lk_req", BW'(tcdm_req_o), BW'(9'h1FE));
      chk("lk_busy", BW'(busy_o), 1);
      step(); rst_ni = 1'b0; idle_in(); #2;
      chk("rst_gnt", BW'(gnt_o), 0);
      chk("rst_rvalid", BW'(r_valid_o), 0);
      chk("rst_tcdm_req", BW'(tcdm_req_o), 0);
      chk("rst_busy", BW'(busy_o), 0);
      chk("rst_err", BW'(err_o), 0);
      step(); step(); rst_ni = 1'b1;
      step(); req_i = 2'b11; tcdm_gnt_i = '1; #2;
      chk("post_rst_gnt", BW'(gnt_o), BW'(2'b01));
      step(); idle_in();
      step(); rsp('1, 32'h7700_0000); #2;
      chk("post_rst_rvalid", BW'(r_valid_o), BW'(2'b01));
      step(); idle_in();
      step(); step();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
